quad_decoder: RTL and testbench

QUAD_DECODER -- requirements
Module: quad_decoder

---
 rtl/quad_decoder.sv | 157 +++++++++++++++
 tb/tb_quad_decoder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: two-flop sync + per-phase debounce, x1/x2/x4 counting with wrap or saturation.
// Optional built-in quadrature test generator under QDEC_TESTGEN_EN (adds tm_enable/tm_dir ports).

module qdec_phase #(
  parameter int FILT = 3
) (
  input  logic clk_in,
  input  logic reset,
  input  logic raw_i,
  output logic lvl_o
);
  localparam int CW = $clog2(FILT + 1);

  logic [1:0]    sync_q;
  logic          lvl_q, lvl_d;
  logic [CW-1:0] run_q, run_d;

  // Any sample that matches the current level restarts the run, so glitches die out.
  always_comb begin
    lvl_d = lvl_q;
    run_d = '0;
    if (sync_q[1] != lvl_q) begin
      if (run_q == CW'(FILT - 1)) lvl_d = sync_q[1];
      else                        run_d = run_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
      run_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      lvl_q  <= lvl_d;
      run_q  <= run_d;
    end
  end

  assign lvl_o = lvl_q;
endmodule

module quad_decoder #(
  parameter int WIDTH = 8,
  parameter int FILT  = 3
) (
  input  logic             clk_in,
  input  logic             reset,
`ifdef QDEC_TESTGEN_EN
  input  logic             tm_enable,
  input  logic             tm_dir,
`endif
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic [1:0]       mode,
  input  logic             sat_en,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err
);
  logic [1:0] raw, lvl;  // bit 1 = A, bit 0 = B

`ifdef QDEC_TESTGEN_EN
  logic [3:0] tick_q;
  logic [1:0] gpos_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      tick_q <= '0;
      gpos_q <= '0;
    end else if (!tm_enable) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_q + 4'd1;
      if (tick_q == 4'hF) gpos_q <= tm_dir ? gpos_q + 2'd1 : gpos_q - 2'd1;
    end
  end

  // Sequence index 0..3 maps to AB = 00,10,11,01.
  assign raw = tm_enable ? {gpos_q[1] ^ gpos_q[0], gpos_q[1]} : {enc_a, enc_b};
`else
  assign raw = {enc_a, enc_b};
`endif

  for (genvar i = 0; i < 2; i++) begin : g_ph
    qdec_phase #(.FILT(FILT)) u_ph (
      .clk_in(clk_in),
      .reset (reset),
      .raw_i (raw[i]),
      .lvl_o (lvl[i])
    );
  end

  logic [1:0]       prev_q;
  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d, step_q, step_d, err_q, err_d;
  logic [1:0]       pos_new, pos_old, delta;
  logic             fwd, rev, illegal, counted;

  // Position along the forward sequence; delta 1 = forward, 3 = reverse, 2 = both phases moved.
  assign pos_new = {lvl[0], lvl[1] ^ lvl[0]};
  assign pos_old = {prev_q[0], prev_q[1] ^ prev_q[0]};
  assign delta   = pos_new - pos_old;
  assign fwd     = (delta == 2'd1);
  assign rev     = (delta == 2'd3);
  assign illegal = (delta == 2'd2);

  always_comb begin
    case (mode)
      2'd0:    counted = (pos_old == 2'd0 && pos_new == 2'd1) || (pos_old == 2'd1 && pos_new == 2'd0);
      2'd1:    counted = (fwd | rev) & (lvl[1] ^ prev_q[1]);
      default: counted = fwd | rev;
    endcase
  end

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    err_d   = err_q;
    if (clear) begin
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      if (illegal) err_d = 1'b1;
      if (counted) begin
        step_d = 1'b1;
        dir_d  = fwd;
        if (fwd) count_d = (sat_en && (&count_q))  ? count_q : count_q + 1'b1;
        else     count_d = (sat_en && ~(|count_q)) ? count_q : count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      prev_q  <= '0;
      count_q <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      prev_q  <= lvl;
      count_q <= count_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      err_q   <= err_d;
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign step  = step_q;
  assign err   = err_q;
endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboarded bench for quad_decoder: driver pushes expected steps, monitor pops on each step pulse.
module tb_quad_decoder;
  localparam int W    = 4;
  localparam int F    = 3;
  localparam int LAT  = F + 3;
  localparam int MAXC = (1 << W) - 1;

  logic         clk_in = 1'b0, reset = 1'b1;
  logic         enc_a = 1'b0, enc_b = 1'b0, sat_en = 1'b0, clear = 1'b0;
  logic [1:0]   mode = 2'd2;
  logic [W-1:0] count;
  logic         dir, step, err;

  typedef struct {
    int           cyc;
    logic [W-1:0] cnt;
    logic         dir;
  } exp_t;

  exp_t q[$];
  int   cyc = 0, checks = 0, errors = 0, nsteps = 0;
  int   pos_m = 0, cnt_m = 0;
  logic [1:0] ab_m = 2'b00;
  logic dir_m = 1'b0, err_m = 1'b0;

  quad_decoder #(.WIDTH(W), .FILT(F)) dut (
    .clk_in(clk_in), .reset(reset),
`ifdef QDEC_TESTGEN_EN
    .tm_enable(1'b0), .tm_dir(1'b0),
`endif
    .enc_a(enc_a), .enc_b(enc_b), .mode(mode), .sat_en(sat_en), .clear(clear),
    .count(count), .dir(dir), .step(step), .err(err)
  );

`ifdef QDEC_TESTGEN_EN
  logic       tge = 1'b0;
  logic [7:0] tg_count;
  logic       tg_dir, tg_step, tg_err;
  quad_decoder #(.WIDTH(8), .FILT(1)) u_tg (
    .clk_in(clk_in), .reset(reset), .tm_enable(tge), .tm_dir(1'b1),
    .enc_a(1'b0), .enc_b(1'b0), .mode(2'd2), .sat_en(1'b0), .clear(1'b0),
    .count(tg_count), .dir(tg_dir), .step(tg_step), .err(tg_err)
  );
`endif

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (!reset && step) begin
      nsteps++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_step: cyc=%0d count=%0d dir=%0d, no step expected", cyc, count, dir);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (count !== e.cnt || dir !== e.dir || cyc != e.cyc) begin
          errors++;
          $display("FAIL step: got cyc=%0d count=%0d dir=%0d, want cyc=%0d count=%0d dir=%0d",
                   cyc, count, dir, e.cyc, e.cnt, e.dir);
        end
      end
    end
  end

  function automatic int a2p(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] p2a(input int p);
    logic [1:0] tbl [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    return tbl[p % 4];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_state(input string nm);
    chk({nm, "_count"}, 32'(count), 32'(cnt_m));
    chk({nm, "_dir"},   32'(dir),   32'(dir_m));
    chk({nm, "_err"},   32'(err),   32'(err_m));
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Called at #1 after an edge; the edge that follows is the first to sample the new level.
  task automatic move(input logic [1:0] ab, input int hold);
    int np, d;
    logic fwd, cnt;
    exp_t e;
    np = a2p(ab);
    d  = (np - pos_m + 4) % 4;
    {enc_a, enc_b} = ab;
    if (d == 2) err_m = 1'b1;
    else if (d != 0) begin
      fwd = (d == 1);
      case (mode)
        2'd0:    cnt = (pos_m == 0 && np == 1) || (pos_m == 1 && np == 0);
        2'd1:    cnt = (ab[1] != ab_m[1]);
        default: cnt = 1'b1;
      endcase
      if (cnt) begin
        if (fwd) cnt_m = (sat_en && cnt_m == MAXC) ? cnt_m : (cnt_m + 1) % (MAXC + 1);
        else     cnt_m = (sat_en && cnt_m == 0) ? 0 : (cnt_m + MAXC) % (MAXC + 1);
        dir_m = fwd;
        e.cyc = cyc + LAT;
        e.cnt = cnt_m[W-1:0];
        e.dir = fwd;
        q.push_back(e);
      end
    end
    pos_m = np;
    ab_m  = ab;
    wait_cyc(hold);
  endtask

  task automatic glitch(input bit on_a, input int g);
    if (on_a) enc_a = ~enc_a; else enc_b = ~enc_b;
    wait_cyc(g);
    if (on_a) enc_a = ~enc_a; else enc_b = ~enc_b;
    wait_cyc(10);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    wait_cyc(1);
    clear = 1'b0;
    cnt_m = 0;
    err_m = 1'b0;
    wait_cyc(2);
  endtask

  task automatic do_reset(input logic [1:0] ab);
    reset = 1'b1;
    {enc_a, enc_b} = ab;
    wait_cyc(4);
    q.delete();
    pos_m = 0; ab_m = 2'b00; cnt_m = 0; dir_m = 1'b0; err_m = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    int s0;
    wait_cyc(3);
    chk("rst_count", 32'(count), 0);
    chk("rst_dir",   32'(dir),   0);
    chk("rst_step",  32'(step),  0);
    chk("rst_err",   32'(err),   0);
    reset = 1'b0;
    wait_cyc(5);

    // full forward x4 cycle
    s0 = nsteps;
    move(2'b10, 10); move(2'b11, 10); move(2'b01, 10); move(2'b00, 10);
    chk("x4_count", 32'(count), 4);
    chk("x4_dir",   32'(dir),   1);
    chk("x4_steps", 32'(nsteps - s0), 4);

    // short glitch is filtered out
    s0 = nsteps;
    glitch(1'b1, 2);
    chk("glitch_count", 32'(count), 4);
    chk("glitch_steps", 32'(nsteps - s0), 0);

    mode = 2'd0;
    move(2'b10, 10); move(2'b11, 10); move(2'b01, 10); move(2'b00, 10);
    chk("x1_count", 32'(count), 5);
    mode = 2'd1;
    move(2'b10, 10); move(2'b11, 10); move(2'b01, 10); move(2'b00, 10);
    chk("x2_count", 32'(count), 7);
    mode = 2'd2;

    // illegal two-phase jump, then clear landing on a step
    move(2'b11, 10);
    chk("illegal_err",   32'(err),   1);
    chk("illegal_count", 32'(count), 7);
    s0 = nsteps;
    {enc_a, enc_b} = 2'b01;
    pos_m = 3; ab_m = 2'b01;
    wait_cyc(LAT - 1);
    clear = 1'b1;
    wait_cyc(1);
    clear = 1'b0;
    cnt_m = 0; err_m = 1'b0;
    chk("clr_step", 32'(step), 0);
    wait_cyc(5);
    chk("clr_count", 32'(count), 0);
    chk("clr_err",   32'(err),   0);
    chk("clr_steps", 32'(nsteps - s0), 0);

    // 17 reverse steps: wrap then saturate
    for (int i = 0; i < 17; i++) move(p2a(pos_m + 3), 8);
    chk("wrap_count", 32'(count), 15);
    pulse_clear();
    sat_en = 1'b1;
    s0 = nsteps;
    for (int i = 0; i < 17; i++) move(p2a(pos_m + 3), 8);
    chk("sat_count", 32'(count), 0);
    chk("sat_dir",   32'(dir),   0);
    chk("sat_steps", 32'(nsteps - s0), 17);
    for (int i = 0; i < 17; i++) move(p2a(pos_m + 1), 8);
    chk("sat_hi_count", 32'(count), 15);

    // randomized walk against the model
    for (int i = 0; i < 200; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) sat_en = 1'($urandom_range(0, 1));
      if (r == 0)      glitch(1'($urandom_range(0, 1)), $urandom_range(1, F - 1));
      else if (r == 1) move(p2a(pos_m + 2), $urandom_range(8, 13));
      else if (r == 2) pulse_clear();
      else             move(p2a(pos_m + (r < 6 ? 1 : 3)), $urandom_range(8, 13));
      chk_state("rnd");
    end

    // non-00 inputs across reset release
    mode = 2'd2;
    do_reset(2'b10);
    move(2'b10, 10);
    chk("rel_adj_count", 32'(count), 1);
    chk("rel_adj_err",   32'(err),   0);
    do_reset(2'b11);
    move(2'b11, 10);
    chk("rel_two_err",   32'(err),   1);
    chk("rel_two_count", 32'(count), 0);

`ifdef QDEC_TESTGEN_EN
    do_reset(2'b00);
    wait_cyc(2);
    tge = 1'b1;
    wait_cyc(650);
    chk("tg_count", 32'(tg_count), 40);
    chk("tg_dir",   32'(tg_dir),   1);
    chk("tg_err",   32'(tg_err),   0);
    tge = 1'b0;
`endif

    wait_cyc(10);
    chk("queue_empty", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
